// File: rtl/y_stream_out.sv
// Output-side consumer of the SSM block: captures the y vector on y_valid and
// streams it as LANES-wide beats over valid/ready, flagging frames that arrive while busy.
//
// state    | meaning
// S_IDLE   | no frame held, waiting for y_valid
// S_STREAM | frame held in frame_q, presenting beat_q downstream

module y_stream_out #(
   parameter int B     = 1,
   parameter int H     = 4,
   parameter int P     = 4,
   parameter int DW    = 16,
   parameter int LANES = 4,
   localparam int HW   = (H > 1) ? $clog2(H) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  y_valid,
   input  logic [B*H*P*DW-1:0]   y_flat,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [LANES*DW-1:0]   out_data,
   output logic [HW-1:0]         out_head,
   output logic                  out_last,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  drop_err,
   output logic [7:0]            drop_cnt,
   input  logic                  clear_err
);

   localparam int TOTAL = B * H * P;
   localparam int BEATS = TOTAL / LANES;
   localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {
      S_IDLE   = 1'b0,
      S_STREAM = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [BTW-1:0]       beat_q, beat_d;
   logic [TOTAL*DW-1:0]  frame_q;
   logic                 frame_done_q;
   logic                 drop_err_q;
   logic [7:0]           drop_cnt_q;

   logic                 capture;
   logic                 xfer;
   logic                 at_last;
   logic                 xfer_last;
   logic                 drop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      capture   = 1'b0;
      drop      = 1'b0;
      xfer      = (state_q == S_STREAM) && out_ready;
      at_last   = (beat_q == BTW'(BEATS - 1));
      xfer_last = xfer && at_last;
      case (state_q)
         S_IDLE: begin
            if (y_valid) begin
               capture = 1'b1;
               beat_d  = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (xfer) begin
               if (at_last) begin
                  beat_d = '0;
                  // a new frame landing exactly on the last transfer is taken without a bubble
                  if (y_valid) capture = 1'b1;
                  else         state_d = S_IDLE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
            if (y_valid && !xfer_last) drop = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            beat_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         if (capture) frame_q <= y_flat;
         frame_done_q <= xfer_last;
      end
   end

   // drop wins over a same-cycle clear so the collision is never silently lost
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_err_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         drop_err_q <= 1'b1;
         if (clear_err)                drop_cnt_q <= 8'd1;
         else if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end else if (clear_err) begin
         drop_err_q <= 1'b0;
         drop_cnt_q <= '0;
      end
   end

   always_comb begin
      int beat_idx;
      int head_idx;
      beat_idx = int'(beat_q);
      head_idx = ((beat_idx * LANES) / P) % H;
      out_data = '0;
      out_head = '0;
      if (state_q == S_STREAM) begin
         out_data = frame_q[beat_idx*LANES*DW +: LANES*DW];
         out_head = HW'(head_idx);
      end
   end

   assign out_valid  = (state_q == S_STREAM);
   assign busy       = (state_q == S_STREAM);
   assign out_last   = (state_q == S_STREAM) && at_last;
   assign frame_done = frame_done_q;
   assign drop_err   = drop_err_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/y_stream_out.md
Name: y_stream_out

Overview:
- Output-side consumer of the SSM block. Captures the full y vector when the SSM block's one-cycle done pulse arrives.
- Streams y as fixed-width beats of LANES fp16 elements over a valid/ready interface toward the out-projection / gating stage.
- Decouples the SSM block's burst result from a back-pressured downstream, with drop detection.

Parameters:
- B, 1, batch size
- H, 4, number of heads
- P, 4, head dimension
- DW, 16, element width (fp16, passed through bit-exact)
- LANES, 4, elements per output beat; P % LANES == 0 required (a beat never spans heads)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- y_valid  input  1  one-cycle pulse meaning y_flat is valid (driven by the SSM block's done)
- y_flat  input  B*H*P*DW  y vector; element k=(b*H+h)*P+p at bits [k*DW +: DW]
- out_ready  input  1  downstream accepts the beat
- out_valid  output  1  beat valid
- out_data  output  LANES*DW  lane j at [j*DW +: DW]
- out_head  output  $clog2(H) (min 1)  head index of the current beat
- out_last  output  1  final beat of the frame
- frame_done  output  1  one-cycle pulse after the last beat is accepted
- busy  output  1  frame held or streaming
- drop_err  output  1  sticky: a y_valid was lost
- drop_cnt  output  8  saturating count of lost frames
- clear_err  input  1  synchronous clear of drop_err and drop_cnt

Behaviour:
- Derived constants: TOTAL=B*H*P; BEATS=TOTAL/LANES.
- Beat i carries elements i*LANES..i*LANES+LANES-1.
- out_head = ((i*LANES)/P) % H.
- out_last = (i == BEATS-1) && out_valid.
- Reset (rst=0, asynchronous): out_valid, out_last, frame_done, busy, drop_err and drop_cnt go to 0; out_head=0; out_data=0; beat counter=0; capture buffer cleared to 0; FSM to IDLE. Reset mid-frame discards the frame. After reset release, no beat is emitted until a new y_valid.
- FSM states:
  - IDLE: out_valid=0, busy=0. On y_valid, register y_flat into the buffer, set beat=0, go to STREAM. out_valid rises the cycle after y_valid is sampled (latency 1).
  - STREAM: out_valid=1, busy=1. out_data is the buffer slice for the current beat.
- Handshake in STREAM:
  - Transfer occurs on out_valid && out_ready.
  - While out_valid && !out_ready, out_data, out_head and out_last hold stable. out_valid never drops without a transfer.
  - On a transfer of beat < BEATS-1: beat increments.
- On transfer of the last beat:
  - frame_done pulses high the next cycle.
  - If y_valid is high in the same cycle: capture the new y_flat, set beat=0, stay in STREAM. out_valid stays 1 with no bubble (back-to-back frames).
  - Otherwise go to IDLE; out_valid=0 the next cycle.
- Drops:
  - y_valid in STREAM, other than in the cycle of the last-beat transfer, is dropped. The buffer is not disturbed.
  - On a drop, drop_err<=1 and drop_cnt increments, saturating at 255.
- clear_err clears drop_err and drop_cnt next cycle. If a drop occurs in the same cycle as clear_err, the drop wins: drop_err=1, drop_cnt=1.
- No arithmetic on data: bits pass unchanged, including NaN/Inf/denormal fp16 patterns.
- out_ready is ignored when out_valid=0.

Test Plan:
- Config for all scenarios: H=4, P=4, LANES=4, element k = 16'h3C00+k.
- Streaming, ready tied 1: pulse y_valid at cycle 0.
  - out_valid on cycles 1-4.
  - beat0 out_data = {3C03,3C02,3C01,3C00}, out_head=0.
  - beat3 out_head=3, out_last=1.
  - frame_done at cycle 5; busy=0 at cycle 5.
- Backpressure: out_ready=0 for cycles 2-4, then 1.
  - beat1 data {3C07..3C04} is held stable for 3 cycles.
  - All 4 beats are delivered in order; out_last appears only on beat3.
- Drop: second y_valid at cycle 2 with different data.
  - Streamed data stays from frame 1.
  - drop_err=1 and drop_cnt=1 at cycle 3.
  - No second frame is emitted.
- Back-to-back: second y_valid (elements 16'h4000+k) in the same cycle as the last-beat transfer.
  - out_valid stays 1 continuously.
  - Next beat = {4003,4002,4001,4000}; drop_err stays 0.
- Reset mid-stream: assert rst=0 during beat2 for one cycle.
  - All outputs are 0 immediately (asynchronous).
  - No beats follow until a new y_valid, which restarts at beat0 / head 0.
- Error clear collision: with drop_cnt=3, assert clear_err and a dropped y_valid in the same cycle.
  - Next cycle drop_err=1, drop_cnt=1.
  - clear_err alone on a later cycle gives 0, 0.
